// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory handshake and the decode-side hand-off.
// master (fetch_unit): drives imem_req/imem_addr, instr_valid/instr/op/pc_out, fetch_count;
//                      receives imem_ack/imem_rdata, instr_ready, pc_src/pc_branch.
// slave (memory + decode/execute side): the mirror image.
interface fetch_unit_if #(parameter int N = 64);
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [10:0]  op;
  logic [N-1:0] pc_out;
  logic         pc_src;
  logic [N-1:0] pc_branch;
  logic [31:0]  fetch_count;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, op, pc_out, fetch_count,
    input  imem_ack, imem_rdata, instr_ready, pc_src, pc_branch
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op, pc_out, fetch_count,
    output imem_ack, imem_rdata, instr_ready, pc_src, pc_branch
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 instruction fetch stage with PC, req/ack memory fetch and held instruction.
// clk   : rising-edge clock
// reset : asynchronous active-low reset
// bus   : fetch_unit_if master (memory handshake, instruction hand-off, redirect, fetch counter)
module fetch_unit #(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);
  localparam logic [1:0] START = 2'd0, FETCH = 2'd1, HOLD = 2'd2;
  logic [1:0]   state_q, state_d;
  logic [N-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
  logic [31:0]  instr_q, instr_d, cnt_q, cnt_d;
  logic         ack, consume;
  assign ack     = state_q == FETCH && bus.imem_ack;
  assign consume = state_q == HOLD && bus.instr_ready;
  // pc is already incremented at the ack, so a consume only overrides it on a taken branch
  always_comb begin
    state_d  = state_q == START ? FETCH : ack ? HOLD : consume ? FETCH : state_q;
    pc_d     = ack ? pc_q + N'(4) : consume && bus.pc_src ? bus.pc_branch & ~N'(3) : pc_q;
    pc_out_d = ack ? pc_q : pc_out_q;
    instr_d  = ack ? bus.imem_rdata : instr_q;
    cnt_d    = consume ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= START;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.imem_req    = state_q == FETCH;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = state_q == HOLD;
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[31:21];
  assign bus.pc_out      = pc_out_q;
  assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst1 = 1'b0;
  logic rst2 = 1'b0;
  int checks = 0;
  int errors = 0;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  fetch_unit_if #(.N(64)) b1 ();
  fetch_unit_if #(.N(64)) b2 ();
  fetch_unit #(.N(64), .RESET_PC(64'd0)) dut  (.clk(clk), .reset(rst1), .bus(b1.master));
  fetch_unit #(.N(64), .RESET_PC(WRAP_PC)) dut2 (.clk(clk), .reset(rst2), .bus(b2.master));
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    case (a)
      64'd0:  return 32'hF840_0000;
      64'd4:  return 32'hF800_0000;
      64'd8:  return 32'hB400_0000;
      64'd12: return 32'h8B02_0020;
      64'd16: return 32'hCB03_0041;
      64'h40: return 32'h9100_0421;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b0;
    repeat (3) step();
    checks++; if (b1.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", b1.imem_req); end
    checks++; if (b1.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", b1.instr_valid); end
    checks++; if (b1.op !== 11'd0) begin errors++; $display("FAIL rst_op got %h exp 0", b1.op); end
    checks++; if (b1.pc_out !== 64'd0) begin errors++; $display("FAIL rst_pc_out got %h exp 0", b1.pc_out); end
    checks++; if (b1.fetch_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", b1.fetch_count); end
    rst1 = 1'b1;
    step();
    checks++; if (b1.imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got %b exp 1", b1.imem_req); end
    checks++; if (b1.imem_addr !== 64'd0) begin errors++; $display("FAIL rel_addr got %h exp 0", b1.imem_addr); end
  endtask

  task automatic test_zero_wait();
    logic [10:0] ops [3];
    ops[0] = 11'b11111000010; ops[1] = 11'b11111000000; ops[2] = 11'b10110100000;
    b1.instr_ready = 1'b1;
    b1.pc_src = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (b1.imem_req !== 1'b1 || b1.imem_addr !== 64'(4 * k)) begin errors++; $display("FAIL zw_req%0d got %b/%h exp 1/%h", k, b1.imem_req, b1.imem_addr, 4 * k); end
      b1.imem_ack = 1'b1;
      b1.imem_rdata = mem(b1.imem_addr);
      step();
      b1.imem_ack = 1'b0;
      checks++; if (b1.instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid%0d got %b exp 1", k, b1.instr_valid); end
      checks++; if (b1.op !== ops[k]) begin errors++; $display("FAIL zw_op%0d got %b exp %b", k, b1.op, ops[k]); end
      checks++; if (b1.pc_out !== 64'(4 * k)) begin errors++; $display("FAIL zw_pc_out%0d got %h exp %h", k, b1.pc_out, 4 * k); end
      step();
      checks++; if (b1.instr_valid !== 1'b0 || b1.fetch_count !== 32'(k + 1)) begin errors++; $display("FAIL zw_consume%0d got %b/%0d exp 0/%0d", k, b1.instr_valid, b1.fetch_count, k + 1); end
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 4; i++) begin
      checks++; if (b1.imem_req !== 1'b1 || b1.imem_addr !== 64'd12 || b1.instr_valid !== 1'b0) begin errors++; $display("FAIL ws_stable%0d got %b/%h/%b exp 1/c/0", i, b1.imem_req, b1.imem_addr, b1.instr_valid); end
      if (i < 3) step();
    end
    b1.instr_ready = 1'b0;
    b1.imem_ack = 1'b1;
    b1.imem_rdata = 32'h8B02_0020;
    step();
    b1.imem_ack = 1'b0;
    checks++; if (b1.instr_valid !== 1'b1 || b1.instr !== 32'h8B02_0020 || b1.pc_out !== 64'd12) begin errors++; $display("FAIL ws_load got %b/%h/%h exp 1/8b020020/c", b1.instr_valid, b1.instr, b1.pc_out); end
    b1.imem_ack = 1'b1;
    b1.imem_rdata = 32'hDEAD_BEEF;
    step();
    b1.imem_ack = 1'b0;
    checks++; if (b1.instr !== 32'h8B02_0020 || b1.instr_valid !== 1'b1) begin errors++; $display("FAIL ws_stray_ack got %h/%b exp 8b020020/1", b1.instr, b1.instr_valid); end
  endtask

  task automatic test_backpressure();
    b1.pc_src = 1'b1;
    b1.pc_branch = 64'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (b1.instr !== 32'h8B02_0020 || b1.op !== 11'h458 || b1.pc_out !== 64'd12 || b1.imem_req !== 1'b0 || b1.fetch_count !== 32'd3) begin
        errors++; $display("FAIL bp_hold%0d got %h/%h/%h/%b/%0d exp 8b020020/458/c/0/3", i, b1.instr, b1.op, b1.pc_out, b1.imem_req, b1.fetch_count);
      end
    end
    b1.pc_src = 1'b0;
    b1.instr_ready = 1'b1;
    step();
    checks++; if (b1.imem_req !== 1'b1 || b1.imem_addr !== 64'd16 || b1.fetch_count !== 32'd4) begin errors++; $display("FAIL bp_resume got %b/%h/%0d exp 1/10/4", b1.imem_req, b1.imem_addr, b1.fetch_count); end
  endtask

  task automatic test_branch();
    b1.imem_ack = 1'b1;
    b1.imem_rdata = mem(b1.imem_addr);
    step();
    b1.imem_ack = 1'b0;
    checks++; if (b1.pc_out !== 64'd16) begin errors++; $display("FAIL br_pc16 got %h exp 10", b1.pc_out); end
    b1.pc_src = 1'b1;
    b1.pc_branch = 64'h0A;
    step();
    b1.pc_src = 1'b0;
    checks++; if (b1.imem_addr !== 64'd8 || b1.imem_req !== 1'b1) begin errors++; $display("FAIL br_to8 got %h/%b exp 8/1", b1.imem_addr, b1.imem_req); end
    b1.imem_ack = 1'b1;
    b1.imem_rdata = mem(b1.imem_addr);
    step();
    b1.imem_ack = 1'b0;
    checks++; if (b1.pc_out !== 64'd8 || b1.op !== 11'b10110100000) begin errors++; $display("FAIL br_at8 got %h/%b exp 8/10110100000", b1.pc_out, b1.op); end
    b1.pc_src = 1'b1;
    b1.pc_branch = 64'h43;
    step();
    b1.pc_src = 1'b0;
    checks++; if (b1.imem_addr !== 64'h40) begin errors++; $display("FAIL br_addr got %h exp 40", b1.imem_addr); end
    b1.imem_ack = 1'b1;
    b1.imem_rdata = mem(b1.imem_addr);
    step();
    b1.imem_ack = 1'b0;
    checks++; if (b1.pc_out !== 64'h40 || b1.instr !== 32'h9100_0421) begin errors++; $display("FAIL br_target got %h/%h exp 40/91000421", b1.pc_out, b1.instr); end
    step();
    checks++; if (b1.fetch_count !== 32'd7) begin errors++; $display("FAIL br_count got %0d exp 7", b1.fetch_count); end
  endtask

  task automatic test_wrap_reset();
    b2.instr_ready = 1'b0;
    b2.pc_src = 1'b0;
    b2.imem_ack = 1'b0;
    rst2 = 1'b1;
    step();
    checks++; if (b2.imem_req !== 1'b1 || b2.imem_addr !== WRAP_PC) begin errors++; $display("FAIL wr_first got %b/%h exp 1/%h", b2.imem_req, b2.imem_addr, WRAP_PC); end
    b2.imem_ack = 1'b1;
    b2.imem_rdata = 32'h1111_1111;
    step();
    b2.imem_ack = 1'b0;
    checks++; if (b2.instr_valid !== 1'b1 || b2.pc_out !== WRAP_PC) begin errors++; $display("FAIL wr_hold got %b/%h exp 1/%h", b2.instr_valid, b2.pc_out, WRAP_PC); end
    b2.instr_ready = 1'b1;
    step();
    checks++; if (b2.imem_req !== 1'b1 || b2.imem_addr !== 64'd0) begin errors++; $display("FAIL wr_addr got %b/%h exp 1/0", b2.imem_req, b2.imem_addr); end
    #2 rst2 = 1'b0;
    #1;
    checks++; if (b2.imem_req !== 1'b0 || b2.instr_valid !== 1'b0 || b2.op !== 11'd0 || b2.pc_out !== 64'd0 || b2.fetch_count !== 32'd0 || b2.instr !== 32'd0) begin
      errors++; $display("FAIL wr_async_rst got %b/%b/%h/%h/%0d exp 0/0/0/0/0", b2.imem_req, b2.instr_valid, b2.op, b2.pc_out, b2.fetch_count);
    end
    checks++; if (b2.imem_addr !== WRAP_PC) begin errors++; $display("FAIL wr_rst_pc got %h exp %h", b2.imem_addr, WRAP_PC); end
    step();
    step();
    rst2 = 1'b1;
    step();
    checks++; if (b2.imem_req !== 1'b1 || b2.imem_addr !== WRAP_PC) begin errors++; $display("FAIL wr_restart got %b/%h exp 1/%h", b2.imem_req, b2.imem_addr, WRAP_PC); end
  endtask

  initial begin
    b1.imem_ack = 1'b0; b1.imem_rdata = '0; b1.instr_ready = 1'b0; b1.pc_src = 1'b0; b1.pc_branch = '0;
    b2.imem_ack = 1'b0; b2.imem_rdata = '0; b2.instr_ready = 1'b0; b2.pc_src = 1'b0; b2.pc_branch = '0;
    #1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_backpressure();
    test_branch();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the LEGv8 single-cycle processor. It owns the program counter, fetches 32-bit instructions from instruction memory over a variable-latency req/ack handshake, and holds each fetched instruction until the decode/execute side accepts it. It presents the opcode field `op` (`instr[31:21]`) directly to `maindec`. It takes branch redirects (`pc_src`, `pc_branch`) from the execute side at the moment an instruction is consumed.

## Interface

Parameters:
- `N`, default 64: PC and address width.
- `RESET_PC`, default 0: PC value loaded on reset. Must be a multiple of 4.

Ports:
- `clk`  in  1: the single clock. All state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  N: fetch address; equals the current PC.
- `imem_ack`  in  1: memory has returned `imem_rdata` this cycle.
- `imem_rdata`  in  32: instruction word; valid only when `imem_ack` is high.
- `instr_valid`  out  1: `instr`, `op` and `pc_out` hold a fetched instruction.
- `instr_ready`  in  1: downstream consumes the instruction this cycle.
- `instr`  out  32: held instruction.
- `op`  out  11: `instr[31:21]`, wired to `maindec.Op`.
- `pc_out`  out  N: address of the held instruction.
- `pc_src`  in  1: branch taken. Sampled only on a consume cycle.
- `pc_branch`  in  N: branch target. Sampled only when `pc_src` is sampled high.
- `fetch_count`  out  32: number of consumed instructions; wraps modulo 2^32.

## Operation

- States: START, FETCH, HOLD.
- `imem_req` is 1 exactly when the state is FETCH. `instr_valid` is 1 exactly when the state is HOLD.
- Reset (`reset`=0, asynchronous) drives:
  - state to START;
  - `pc` to `RESET_PC`;
  - `instr`, `pc_out`, `fetch_count` to 0, so `op` is 0;
  - `imem_req` and `instr_valid` to 0.
- START moves to FETCH on the first rising edge with `reset`=1.
- FETCH:
  - `imem_addr` = `pc`. Address and request stay stable until ack.
  - On `imem_ack`=1: `instr` ← `imem_rdata`; `pc_out` ← `pc`; `pc` ← `pc`+4 (modulo 2^N); next state HOLD.
- HOLD:
  - `instr`, `op`, `pc_out` are held stable. No memory request is issued.
  - On `instr_ready`=1 (consume): `fetch_count` increments; next state FETCH.
  - If `pc_src`=1 on that same edge: `pc` ← `{pc_branch[N-1:2], 2'b00}` (low two bits forced to zero). Otherwise `pc` keeps the already-incremented value.
- `pc_src` and `pc_branch` are ignored in every cycle that is not a consume.
- `imem_ack` outside FETCH is ignored; `imem_rdata` is not captured.
- Reset mid-operation: state returns to START immediately. Any outstanding request is abandoned, and the memory must tolerate a dropped request.

## Timing

- Ack to `instr_valid`=1: one edge. The ack edge loads the instruction and enters HOLD.
- Consume to next `imem_req`=1: one edge.
- Ack may arrive in the same cycle `imem_req` first rises (zero-wait memory). This gives the maximum throughput of one instruction per 2 cycles.
- Each memory wait state adds one cycle. Each `instr_ready`=0 cycle in HOLD adds one cycle.
- Redirect penalty is zero extra cycles: the next `imem_addr` is the branch target.
- `op` is a combinational slice of the `instr` register and has no extra latency.

## Test plan

1. **Reset.** Hold `reset`=0 for 3 cycles.
   - During reset: `imem_req`=0, `instr_valid`=0, `op`=0, `pc_out`=0, `fetch_count`=0.
   - One edge after release: `imem_req`=1, `imem_addr`=0.
2. **Zero-wait memory.** Ack every request. `instr_ready`=1, `pc_src`=0. Memory holds 0xF8400000 at address 0, 0xF8000000 at 4, 0xB4000000 at 8.
   - `op` = 11'b11111000010, then 11'b11111000000, then 11'b10110100000.
   - `pc_out` = 0, 4, 8. `instr_valid` is high every other cycle. `fetch_count` reaches 3.
3. **Memory wait states.** Ack 3 cycles after `imem_req` rises.
   - `imem_addr` and `imem_req` are stable for all 4 cycles.
   - `instr_valid` rises exactly one edge after the ack.
   - A stray `imem_ack` pulse during HOLD does not change `instr`.
4. **Backpressure.** Hold `instr_ready`=0 for 5 cycles in HOLD.
   - `instr`, `op`, `pc_out` are unchanged. `imem_req`=0. `fetch_count` is unchanged.
   - Assert `pc_src`=1 with `pc_branch`=0x80 during those cycles: the redirect is ignored and the next `imem_addr` = `pc_out`+4.
5. **Branch redirect.** At `pc_out`=8, consume with `pc_src`=1 and `pc_branch`=0x43.
   - Next `imem_addr` = 0x40. `pc_out` of the following instruction = 0x40.
6. **Wrap and reset mid-fetch.**
   - With `RESET_PC`=2^N−4: after the first fetch, `imem_addr`=0.
   - Assert `reset`=0 while `imem_req`=1 and before ack: all outputs return to reset values immediately, without waiting for a clock edge.
   - After release, the fetch restarts at `RESET_PC`.
